// File: rtl/feather_pkg.sv
// Shared types and constants for the fetch stage.
//   fetch_state_e : fetch FSM states (RUN / HALT / FAULT)
//   fetch_entry_t : default fetch-buffer entry {pc, instr} for an 8-bit PC, 32-bit instruction
//   INSTR_BYTES   : bytes per instruction (PC increment)
package feather_pkg;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer. The head comes straight out of the storage
// registers, so an entry pushed at an edge is visible right after it.
// Ports:
//   clk_i, rst_ni           clock / async active-low reset (storage cleared to 0)
//   push_i, pop_i, flush_i  write, consume head, discard all (flush dominant)
//   data_i                  entry to write
//   head_o                  oldest entry (meaningful only when !empty_o)
//   full_o, empty_o         occupancy flags
module fetch_fifo
  import feather_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 2
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   push_i,
  input  logic   pop_i,
  input  logic   flush_i,
  input  entry_t data_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);
  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      // storage left as-is; it is unreachable until rewritten
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_i) rd_q <= rd_q + PW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads program memory combinationally and
// buffers {pc, instr} for decode behind a valid/ready handshake.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps
// into a terminal FAULT state; otherwise redirect targets are word-aligned).
// Ports:
//   clk_i, rst_ni                 clock / async active-low reset
//   redirect_i, redirect_addr_i   branch/jump: flush buffer, load PC
//   halt_i                        stop issuing fetches (buffer still drains)
//   imem_addr_o, imem_instr_i     program memory byte address / returned word
//   instr_valid_o, instr_ready_i  decode handshake
//   instr_o, instr_pc_o           head instruction and its PC
//   fault_o                       sticky misaligned-redirect trap
module instruction_fetch
  import feather_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                INSTR_W    = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_addr_i,
  input  logic               halt_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  instr_pc_o,
  output logic               fault_o
);
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt;
  logic              fetch_en, push, pop, flush, full, empty, mis;
  entry_t            head, wdata;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;
  assign mis = redirect_i && (redirect_addr_i[1:0] != 2'b00);
  assign tgt = redirect_addr_i;   // kept raw so the bad target is visible on imem_addr_o

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fault_q <= 1'b0;
    else if (mis && state_q != FAULT) fault_q <= 1'b1;
  end
  assign fault_o = fault_q;
`else
  assign mis     = 1'b0;
  assign tgt     = redirect_addr_i & ~ADDR_W'(INSTR_BYTES - 1);
  assign fault_o = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_i)  state_d = HALT;
      HALT:    if (!halt_i) state_d = RUN;
      FAULT:   state_d = FAULT;
      default: state_d = RUN;
    endcase
    if (mis && state_q != FAULT) state_d = FAULT;
  end

  // FSM: outputs
  always_comb begin
    fetch_en = (state_q == RUN);
  end

  // Redirect kills this cycle's pop and push; a full buffer may still take a
  // new word when its head leaves in the same cycle.
  assign pop   = !empty && instr_ready_i && !redirect_i;
  assign push  = fetch_en && !redirect_i && (!full || pop);
  assign flush = redirect_i && (state_q != FAULT);
  assign wdata = '{pc: pc_q, instr: imem_instr_i};

  always_comb begin
    pc_d = pc_q;
    if (state_q == FAULT) pc_d = pc_q;
    else if (redirect_i)  pc_d = tgt;
    else if (push)        pc_d = pc_q + ADDR_W'(INSTR_BYTES);   // wraps modulo 2^ADDR_W
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= RESET_PC;
    else         pc_q <= pc_d;
  end

  fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (wdata),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign imem_addr_o   = pc_q;
  assign instr_valid_o = !empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;
endmodule
